// File: rtl/red_pitaya_pwm_pkg.sv
// -----------------------------------------------------------------------------
// red_pitaya_pwm_pkg
// Shared definitions for the PWM modulator and the DSP top-level that routes
// the pwm0/pwm1 samples into it.
//   PWM_CNT_BITS : default PWM period counter width (period = 2^PWM_CNT_BITS)
//   PWM_DAT_BITS : default width of the signed sample fed to the modulator
//   PWM_FRAC_BITS: sample bits below the duty resolution (dither fraction)
//   pwm_duty_t   : duty count at the default width, 0..2^PWM_CNT_BITS
// -----------------------------------------------------------------------------
package red_pitaya_pwm_pkg;

    localparam int PWM_CNT_BITS  = 8;
    localparam int PWM_DAT_BITS  = 14;
    localparam int PWM_FRAC_BITS = PWM_DAT_BITS - PWM_CNT_BITS;

    // One bit wider than the counter so a full-high period (2^CNT_BITS) fits.
    typedef logic [PWM_CNT_BITS:0] pwm_duty_t;

endpackage : red_pitaya_pwm_pkg

// File: rtl/red_pitaya_pwm_dither.sv
// -----------------------------------------------------------------------------
// red_pitaya_pwm_dither
// Offset conversion of the signed sample plus a first-order sigma-delta
// accumulator on the sub-LSB fraction. Built only when PWM_DITHER_EN is
// defined; without it the top truncates the fraction itself.
// Ports:
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   en_i          : modulator enable; accumulator is cleared while low
//   sample_i      : high in the cycle the top latches a new duty
//   dat_i         : signed two's-complement sample
//   coarse_o      : upper CNT_BITS of the offset sample
//   carry_o       : overflow of acc + frac, added to the coarse duty
// -----------------------------------------------------------------------------
`ifdef PWM_DITHER_EN
module red_pitaya_pwm_dither
    import red_pitaya_pwm_pkg::*;
#(
    parameter int CNT_BITS = PWM_CNT_BITS,
    parameter int DAT_BITS = PWM_DAT_BITS
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       en_i,
    input  logic                       sample_i,
    input  logic signed [DAT_BITS-1:0] dat_i,
    output logic        [CNT_BITS-1:0] coarse_o,
    output logic                       carry_o
);

    localparam int FRAC_BITS = DAT_BITS - CNT_BITS;

    logic [DAT_BITS-1:0]  off;
    logic [FRAC_BITS:0]   sum;
    logic [FRAC_BITS-1:0] acc_q, acc_d;

    // Adding 2^(DAT_BITS-1) to a two's-complement value is an MSB inversion.
    assign off      = {~dat_i[DAT_BITS-1], dat_i[DAT_BITS-2:0]};
    assign coarse_o = off[DAT_BITS-1:FRAC_BITS];
    assign sum      = {1'b0, acc_q} + {1'b0, off[FRAC_BITS-1:0]};
    assign carry_o  = sum[FRAC_BITS];

    always_comb begin
        acc_d = acc_q;
        if (!en_i) begin
            acc_d = '0;
        end else if (sample_i) begin
            acc_d = sum[FRAC_BITS-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule : red_pitaya_pwm_dither
`endif

// File: rtl/red_pitaya_pwm_modulator.sv
// -----------------------------------------------------------------------------
// red_pitaya_pwm_modulator
// Converts a signed DSP sample into a PWM bit stream with a period of
// 2^CNT_BITS clocks. The sample is taken in the last cycle of each period and
// drives the whole following period. Optional sub-LSB dithering is enabled by
// defining the macro PWM_DITHER_EN (default: fraction truncated).
// Ports:
//   clk_i    : processing clock
//   rstn_i   : asynchronous active-low reset
//   dat_i    : signed two's-complement sample (DAT_BITS)
//   en_i     : modulator enable; low holds outputs at zero
//   pwm_o    : registered PWM bit
//   period_o : one-cycle strobe in the first cycle of every period
//   duty_o   : high-cycle count of the current period, 0..2^CNT_BITS
// -----------------------------------------------------------------------------
module red_pitaya_pwm_modulator
    import red_pitaya_pwm_pkg::*;
#(
    parameter int CNT_BITS = PWM_CNT_BITS,
    parameter int DAT_BITS = PWM_DAT_BITS
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic signed [DAT_BITS-1:0] dat_i,
    input  logic                       en_i,
    output logic                       pwm_o,
    output logic                       period_o,
    output logic        [CNT_BITS:0]   duty_o
);

    localparam int FRAC_BITS = DAT_BITS - CNT_BITS;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS:0]   duty_q, duty_d;
    logic                pwm_q, pwm_d;
    logic                period_q, period_d;

    logic [CNT_BITS-1:0] coarse;
    logic                carry;
    logic                sample;
    logic [CNT_BITS:0]   high;

    // The counter idles at its maximum, so the first enabled edge is already a
    // sample edge and the first period starts one clock after enable.
    assign sample = en_i && (cnt_q == CNT_MAX);
    assign high   = {1'b0, coarse} + {{CNT_BITS{1'b0}}, carry};

`ifdef PWM_DITHER_EN
    red_pitaya_pwm_dither #(
        .CNT_BITS (CNT_BITS),
        .DAT_BITS (DAT_BITS)
    ) u_dither (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .en_i     (en_i),
        .sample_i (sample),
        .dat_i    (dat_i),
        .coarse_o (coarse),
        .carry_o  (carry)
    );
`else
    logic [DAT_BITS-1:0] off;
    logic                unused_frac;

    assign off         = {~dat_i[DAT_BITS-1], dat_i[DAT_BITS-2:0]};
    assign coarse      = off[DAT_BITS-1:FRAC_BITS];
    assign carry       = 1'b0;
    // The fraction is deliberately dropped when dithering is not built in.
    assign unused_frac = ^off[FRAC_BITS-1:0];
`endif

    // NOTE: every signal gets a default before the branches so no path leaves
    // it unassigned; a missing default would infer a latch.
    always_comb begin
        cnt_d    = cnt_q;
        duty_d   = duty_q;
        pwm_d    = 1'b0;
        period_d = 1'b0;
        if (!en_i) begin
            cnt_d  = CNT_MAX;
            duty_d = '0;
        end else if (sample) begin
            cnt_d    = '0;
            duty_d   = high;
            period_d = 1'b1;
            pwm_d    = (high != '0);
        end else begin
            cnt_d = cnt_q + 1'b1;
            // pwm_o is registered, so compare against the count it will show.
            pwm_d = ({1'b0, cnt_d} < duty_q);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q    <= CNT_MAX;
            duty_q   <= '0;
            pwm_q    <= 1'b0;
            period_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
            period_q <= period_d;
        end
    end

    assign pwm_o    = pwm_q;
    assign period_o = period_q;
    assign duty_o   = duty_q;

endmodule : red_pitaya_pwm_modulator

// File: tb/tb_red_pitaya_pwm_modulator.sv
// -----------------------------------------------------------------------------
// tb_red_pitaya_pwm_modulator
// Scoreboard bench: a reference model pushes the expected outputs of every
// clock into a queue; an independent monitor pops and compares them. Directed
// segments add whole-window high-cycle totals and reset/enable edge checks.
// Build with PWM_DITHER_EN defined to exercise the dithered variant.
// -----------------------------------------------------------------------------
module tb_red_pitaya_pwm_modulator;

    localparam int CNT_BITS = 8;
    localparam int DAT_BITS = 14;
    localparam int PERIOD   = 1 << CNT_BITS;
    localparam int SCALE    = 1 << (DAT_BITS - CNT_BITS);
    localparam int HALF     = 1 << (DAT_BITS - 1);

`ifdef PWM_DITHER_EN
    localparam int EXP_HI_MAX = 63 * 256 + 255;
    localparam int EXP_HI_ONE = 64 * 128 + 1;
`else
    localparam int EXP_HI_MAX = 64 * 255;
    localparam int EXP_HI_ONE = 64 * 128;
`endif

    logic                       clk_i = 1'b0;
    logic                       rstn_i = 1'b0;
    logic signed [DAT_BITS-1:0] dat_i = '0;
    logic                       en_i = 1'b1;
    logic                       pwm_o;
    logic                       period_o;
    logic        [CNT_BITS:0]   duty_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int pwm;
        int period;
        int duty;
    } exp_t;

    exp_t exp_q[$];

    red_pitaya_pwm_modulator #(
        .CNT_BITS (CNT_BITS),
        .DAT_BITS (DAT_BITS)
    ) dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .dat_i    (dat_i),
        .en_i     (en_i),
        .pwm_o    (pwm_o),
        .period_o (period_o),
        .duty_o   (duty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: position within the period (-1 = idle), the duty of
    // the running period and the dither remainder, all in plain integers.
    int m_phase = -1;
    int m_duty  = 0;
    int m_acc   = 0;
    int m_off;

    always @(posedge clk_i) begin
        exp_t e;
        if (!rstn_i || !en_i) begin
            m_phase = -1;
            m_duty  = 0;
            m_acc   = 0;
        end else if (m_phase == -1 || m_phase == PERIOD - 1) begin
            m_off  = int'(dat_i) + HALF;
            m_duty = m_off / SCALE;
`ifdef PWM_DITHER_EN
            m_acc = m_acc + (m_off % SCALE);
            if (m_acc >= SCALE) begin
                m_acc  = m_acc - SCALE;
                m_duty = m_duty + 1;
            end
`endif
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
        end
        e.pwm    = (m_phase >= 0 && m_phase < m_duty) ? 1 : 0;
        e.period = (m_phase == 0) ? 1 : 0;
        e.duty   = m_duty;
        exp_q.push_back(e);
    end

    // Monitor: compares once per clock, 1 time unit after the edge.
    always @(posedge clk_i) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pwm_o", int'(pwm_o), e.pwm);
            check("period_o", int'(period_o), e.period);
            check("duty_o", int'(duty_o), e.duty);
        end
    end

    // Leaves the bench at a falling edge with en_i just raised: the next
    // rising edge starts a period with the accumulator cleared.
    task automatic restart(input int d);
        @(negedge clk_i);
        en_i  = 1'b0;
        dat_i = DAT_BITS'(d);
        @(negedge clk_i);
        en_i = 1'b1;
    endtask

    // After restart: stop at the falling edge inside the cycle with cnt == c.
    task automatic to_cnt(input int c);
        repeat (c + 1) @(negedge clk_i);
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
            hi += int'(pwm_o);
        end
    endtask

    initial begin
        int hi;

        // Reset state.
        repeat (3) @(negedge clk_i);
        check("reset_pwm", int'(pwm_o), 0);
        check("reset_period", int'(period_o), 0);
        check("reset_duty", int'(duty_o), 0);
        rstn_i = 1'b1;

        // Mid-scale: 128 high cycles per period.
        count_high(PERIOD, hi);
        check("mid_first_period_high", hi, 128);
        repeat (2 * PERIOD) @(negedge clk_i);

        // Full negative scale: never high.
        restart(-HALF);
        count_high(2 * PERIOD, hi);
        check("neg_full_high", hi, 0);

        // Sample change mid-period does not disturb the running period.
        restart(0);
        to_cnt(50);
        dat_i = DAT_BITS'(-HALF);
        repeat (2 * PERIOD) @(negedge clk_i);

        // Full positive scale and one LSB above mid-scale over 64 periods.
        restart(HALF - 1);
        count_high(64 * PERIOD, hi);
        check("pos_full_64_high", hi, EXP_HI_MAX);
        restart(1);
        count_high(64 * PERIOD, hi);
        check("one_lsb_64_high", hi, EXP_HI_ONE);

        // Enable dropped at cnt 60, then re-raised.
        restart(0);
        to_cnt(60);
        check("pre_drop_pwm", int'(pwm_o), 1);
        en_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("drop_pwm", int'(pwm_o), 0);
        @(negedge clk_i);
        en_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("reraise_period", int'(period_o), 1);
        check("reraise_duty", int'(duty_o), 128);

        // Reset pulse at cnt 60: outputs clear immediately, then restart.
        restart(0);
        to_cnt(60);
        rstn_i = 1'b0;
        #1;
        check("async_reset_pwm", int'(pwm_o), 0);
        check("async_reset_duty", int'(duty_o), 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("post_reset_period", int'(period_o), 1);
        check("post_reset_duty", int'(duty_o), 128);

        // Randomized samples, enable toggles and reset pulses.
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk_i);
            rstn_i = 1'b1;
            if ($urandom_range(0, 40) == 0) dat_i = DAT_BITS'($urandom);
            if ($urandom_range(0, 400) == 0) en_i = ~en_i;
            if ($urandom_range(0, 1500) == 0) rstn_i = 1'b0;
        end
        @(negedge clk_i);
        rstn_i = 1'b1;
        en_i   = 1'b1;
        repeat (2 * PERIOD) @(negedge clk_i);

        repeat (2) @(posedge clk_i);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_red_pitaya_pwm_modulator

// File: doc/red_pitaya_pwm_modulator.md
RED_PITAYA_PWM_MODULATOR -- requirements
Module: red_pitaya_pwm_modulator

Interface
REQ-001 Parameter CNT_BITS, default 8: PWM period counter width; period = 2^CNT_BITS clocks.
REQ-002 Parameter DAT_BITS, default 14: width of the signed input sample; FRAC_BITS = DAT_BITS-CNT_BITS (6 at defaults).
REQ-003 clk_i  input  1  processing clock; the only clock.
REQ-004 rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 dat_i  input  DAT_BITS  signed two's-complement sample (the pwm0/pwm1 routing output of the DSP bus).
REQ-006 en_i  input  1  modulator enable.
REQ-007 pwm_o  output  1  registered PWM bit to the analog-mixed-signal pin driver.
REQ-008 period_o  output  1  one-cycle strobe, high in the first cycle of each PWM period.
REQ-009 duty_o  output  CNT_BITS+1  high-cycle count of the current period, 0..2^CNT_BITS.

Function
REQ-010 Offset conversion SHALL be off = dat_i + 2^(DAT_BITS-1), unsigned 0..2^DAT_BITS-1 (invert MSB); -8192 -> 0, 0 -> 8192, 8191 -> 16383.
REQ-011 coarse = off[DAT_BITS-1:FRAC_BITS]; frac = off[FRAC_BITS-1:0].
REQ-012 Counter cnt SHALL run 0..2^CNT_BITS-1 and wrap to 0 while en_i is high.
REQ-013 dat_i SHALL be sampled only in the cycle with cnt == 2^CNT_BITS-1; changes at any other time SHALL NOT affect the running period.
REQ-014 At that sample edge, high = coarse + carry (CNT_BITS+1 bits, range 0..2^CNT_BITS) SHALL be latched into duty_o.
REQ-015 pwm_o SHALL be high in exactly the first duty_o cycles of each period and low for the rest; duty_o = 2^CNT_BITS yields a full-high period with no low glitch at the wrap.
REQ-016 Latency: the period using a sample starts on the clock after the sample edge, i.e. period_o and the first pwm_o cycle of that duty coincide.
REQ-017 When en_i is low: cnt held at 2^CNT_BITS-1, pwm_o = 0, period_o = 0, duty_o = 0, dither accumulator = 0.
REQ-018 On en_i rising, the first sample edge SHALL be the same cycle (cnt already at max), so the first period starts one clock after en_i rises.
REQ-019 en_i falling mid-period SHALL force pwm_o low on the next clock; the partial period is abandoned.

Reset
REQ-020 While rstn_i is low, asynchronously: cnt = 2^CNT_BITS-1, pwm_o = 0, period_o = 0, duty_o = 0, accumulator = 0.
REQ-021 After rstn_i deasserts, behaviour SHALL be as for en_i rising (REQ-018) if en_i is high; reset mid-period discards that period.

Configuration
REQ-022 Macro PWM_DITHER_EN defined: FRAC_BITS-wide accumulator acc; at each sample edge {carry, acc} <= acc + frac (first-order sigma-delta), so the mean duty over 2^FRAC_BITS periods equals off / 2^FRAC_BITS clocks.
REQ-023 Macro PWM_DITHER_EN undefined: no accumulator, carry = 0, frac discarded (truncation).

Structure
REQ-024 Shared package red_pitaya_pwm_pkg SHALL hold CNT_BITS/DAT_BITS defaults and the duty-count type; the DSP top-level imports it for pwm0/pwm1 widths.
REQ-025 One sub-module, red_pitaya_pwm_dither (offset conversion + accumulator), compiled only under PWM_DITHER_EN; counter and comparator stay in the top.

Verification
REQ-026 dat_i = -8192, en_i = 1 -> pwm_o 0 for all 256 cycles of every period; duty_o = 0.
REQ-027 dat_i = 0 -> duty_o = 128 every period; pwm_o high cycles 0..127, low 128..255; period_o every 256 clocks.
REQ-028 dat_i = 8191 with PWM_DITHER_EN -> 63 of every 64 periods duty_o = 256 (pwm_o continuously high), 1 period duty_o = 255; without macro every period duty_o = 255.
REQ-029 dat_i = 1 with PWM_DITHER_EN -> exactly 1 period of each 64 has duty_o = 129, others 128; total high cycles over 64 periods = 8193.
REQ-030 dat_i switched 0 -> -8192 at cnt = 50 -> current period keeps 128 high cycles; next period 0.
REQ-031 en_i dropped at cnt = 60 with duty 128 -> pwm_o low next clock; en_i re-raised -> period_o one clock later, accumulator restarted from 0; rstn_i pulse at cnt = 60 gives the same response.
